led_sense_sequencer: RTL and testbench



---
 rtl/led_sense_if.sv | 25 ++
 rtl/led_sense_sequencer.sv | 97 +++++++++
 tb/tb_led_sense_sequencer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/led_sense_if.sv
// Handshake and result bundle between the LED/sense sequencer and its controller.
// The master drives requests and the comparator input; the slave returns the results.
interface led_sense_if #(
  parameter int CW = 4
);
  logic          start;
  logic          abort;
  logic          comp_in;
  logic          led_en;
  logic          latch_clr;
  logic          busy;
  logic          result_valid;
  logic [CW-1:0] count;
  logic          detect;

  modport master (
    output start, abort, comp_in,
    input  led_en, latch_clr, busy, result_valid, count, detect
  );

  modport slave (
    input  start, abort, comp_in,
    output led_en, latch_clr, busy, result_valid, count, detect
  );
endinterface

// File: rtl/led_sense_sequencer.sv
// Sequencer for the LED/sense front end: clear the latch, let the LED settle,
// count comparator-high samples over a window, then report count and detect.
module led_sense_sequencer #(
  parameter int SETTLE_CYC = 4,
  parameter int NSAMP      = 8,
  parameter int THRESH     = 5,
  parameter int CW         = $clog2(NSAMP + 1)
) (
  input logic        clk,
  input logic        rst,
  led_sense_if.slave bus
);

  localparam int MAXP = (SETTLE_CYC > NSAMP) ? SETTLE_CYC : NSAMP;
  localparam int PW   = $clog2(MAXP + 1);
  localparam logic [PW-1:0] SETTLE_LAST = PW'(SETTLE_CYC - 1);
  localparam logic [PW-1:0] SAMP_LAST   = PW'(NSAMP - 1);
  localparam logic [CW-1:0] THRESH_C    = CW'(THRESH);

  typedef enum logic [2:0] {IDLE, CLEAR, SETTLE, SAMPLE, DONE} state_t;

  state_t        state, state_next;
  logic [PW-1:0] phase;
  logic [CW-1:0] acc;
  logic [CW-1:0] acc_next;
  logic [CW-1:0] count_r;
  logic          detect_r;
  logic          comp_p0;
  logic          comp_sync;

  function automatic logic meets_thresh(input logic [CW-1:0] v);
    return v >= THRESH_C;
  endfunction

  assign acc_next = acc + CW'(comp_sync);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = CLEAR;
      CLEAR:   state_next = bus.abort ? IDLE : SETTLE;
      SETTLE:  if (bus.abort)               state_next = IDLE;
               else if (phase == SETTLE_LAST) state_next = SAMPLE;
      SAMPLE:  if (bus.abort)               state_next = IDLE;
               else if (phase == SAMP_LAST)   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.led_en       = (state == SETTLE) || (state == SAMPLE);
    bus.latch_clr    = (state == CLEAR);
    bus.busy         = (state != IDLE);
    bus.result_valid = (state == DONE);
    bus.count        = count_r;
    bus.detect       = detect_r;
  end

  // comp_p0 may go metastable; only comp_sync feeds the accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      comp_p0   <= 1'b0;
      comp_sync <= 1'b0;
      phase     <= '0;
      acc       <= '0;
      count_r   <= '0;
      detect_r  <= 1'b0;
    end else begin
      comp_p0   <= bus.comp_in;
      comp_sync <= comp_p0;
      case (state)
        CLEAR: begin
          acc   <= '0;
          phase <= '0;
        end
        SETTLE: phase <= (phase == SETTLE_LAST) ? '0 : phase + PW'(1);
        SAMPLE: begin
          acc   <= acc_next;
          phase <= phase + PW'(1);
          // results are loaded on the edge into DONE so they are valid with the strobe
          if (state_next == DONE) begin
            count_r  <= acc_next;
            detect_r <= meets_thresh(acc_next);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_led_sense_sequencer.sv
// Directed bench for led_sense_sequencer: per-cycle output checks plus a
// result scoreboard filled at each accepted start and drained on result_valid.
module tb_led_sense_sequencer;

  localparam int S  = 4;
  localparam int N  = 8;
  localparam int T  = 5;
  localparam int CW = $clog2(N + 1);
  localparam int DONE_CYC = S + N + 2;

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic          det;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   errors  = 0;
  int   rv_seen = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  led_sense_if #(.CW(CW)) dif ();

  led_sense_sequencer #(
    .SETTLE_CYC(S),
    .NSAMP(N),
    .THRESH(T),
    .CW(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(dif)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic comp_at(input int mode, input int k);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return k[0];
      3:       return (k >= 7) && (k <= 11);
      4:       return k >= 15;
      default: return 1'b0;
    endcase
  endfunction

  // comp_in driven in cycle k is seen by the accumulator in cycle k+2
  function automatic res_t expect_res(input int mode, input int base);
    res_t r;
    int   sum = 0;
    for (int k = base + S; k < base + S + N; k++) sum += int'(comp_at(mode, k));
    r.cnt = CW'(sum);
    r.det = (sum >= T);
    return r;
  endfunction

  task automatic step(input logic st, input logic ab, input logic cp, input logic rs);
    dif.start   = st;
    dif.abort   = ab;
    dif.comp_in = cp;
    rst         = rs;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (dif.result_valid === 1'b1) begin
      res_t e;
      rv_seen++;
      vectors++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_result_valid: observed count %0d, required no strobe", dif.count);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_count", 32'(dif.count), 32'(e.cnt));
        chk("sb_detect", 32'(dif.detect), 32'(e.det));
      end
    end
  end

  task automatic run_meas(input int mode, input logic ab0);
    res_t e;
    int   j;
    e = expect_res(mode, 0);
    exp_q.push_back(e);
    for (int k = 0; k <= DONE_CYC; k++) begin
      step(k == 0, (k == 0) && ab0, comp_at(mode, k), 1'b0);
      j = k + 1;
      chk("latch_clr", 32'(dif.latch_clr), 32'(j == 1));
      chk("led_en", 32'(dif.led_en), 32'((j >= 2) && (j <= S + N + 1)));
      chk("busy", 32'(dif.busy), 32'((j >= 1) && (j <= DONE_CYC)));
      chk("result_valid", 32'(dif.result_valid), 32'(j == DONE_CYC));
    end
    chk("count_hold", 32'(dif.count), 32'(e.cnt));
    chk("detect_hold", 32'(dif.detect), 32'(e.det));
  endtask

  initial begin
    int j;
    int rv_base;
    dif.start = 1'b0;
    dif.abort = 1'b0;
    dif.comp_in = 1'b0;
    rst = 1'b1;

    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_led_en", 32'(dif.led_en), 0);
    chk("rst_latch_clr", 32'(dif.latch_clr), 0);
    chk("rst_busy", 32'(dif.busy), 0);
    chk("rst_result_valid", 32'(dif.result_valid), 0);
    chk("rst_count", 32'(dif.count), 0);
    chk("rst_detect", 32'(dif.detect), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // comp low, then comp high, then a one-cycle reset
    run_meas(0, 1'b0);
    run_meas(1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst2_count", 32'(dif.count), 0);
    chk("rst2_detect", 32'(dif.detect), 0);
    chk("rst2_led_en", 32'(dif.led_en), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // toggling comp gives 4, late window gives exactly THRESH
    run_meas(2, 1'b0);
    run_meas(3, 1'b0);

    // abort in the first SAMPLE cycle
    for (int k = 0; k <= 16; k++) begin
      step(k == 0, k == 6, 1'b1, 1'b0);
      j = k + 1;
      chk("abort_led_en", 32'(dif.led_en), 32'((j >= 2) && (j <= 6)));
      chk("abort_busy", 32'(dif.busy), 32'((j >= 1) && (j <= 6)));
      chk("abort_result_valid", 32'(dif.result_valid), 0);
    end
    chk("abort_count_kept", 32'(dif.count), 5);
    chk("abort_detect_kept", 32'(dif.detect), 1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("idle_abort_busy", 32'(dif.busy), 0);
    run_meas(0, 1'b1);

    // extra starts while busy and in DONE are dropped; first IDLE start taken
    rv_base = rv_seen;
    for (int k = 0; k <= 29; k++) begin
      if (k == 0)  exp_q.push_back(expect_res(4, 0));
      if (k == 15) exp_q.push_back(expect_res(4, 15));
      step((k == 0) || (k == 3) || (k == 14) || (k == 15), 1'b0, comp_at(4, k), 1'b0);
      j = k + 1;
      chk("restart_result_valid", 32'(dif.result_valid), 32'((j == 14) || (j == 29)));
      chk("restart_busy", 32'(dif.busy), 32'(((j >= 1) && (j <= 14)) || ((j >= 16) && (j <= 29))));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("restart_strobes", 32'(rv_seen - rv_base), 2);
    chk("restart_count", 32'(dif.count), 8);

    // reset mid-measurement with start on the same edge
    for (int k = 0; k <= 15; k++) begin
      step((k == 0) || (k == 10), 1'b0, 1'b1, k == 10);
      j = k + 1;
      if (j == 11) begin
        chk("rstmid_led_en", 32'(dif.led_en), 0);
        chk("rstmid_latch_clr", 32'(dif.latch_clr), 0);
        chk("rstmid_count", 32'(dif.count), 0);
        chk("rstmid_detect", 32'(dif.detect), 0);
      end
      chk("rstmid_busy", 32'(dif.busy), 32'((j >= 1) && (j <= 10)));
      chk("rstmid_result_valid", 32'(dif.result_valid), 0);
    end

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
